// File: rtl/ffa_pkg.sv
// rtl/ffa_pkg.sv - shared op codes, error codes and issuer state for the GF(2^8) command issuer
package ffa_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_INV = 3'd4;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    localparam logic [8:0] IRR_POLY = 9'h11B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_INV_WAIT,
        ST_DRAIN,
        ST_RESP
    } issuer_state_t;

endpackage

// File: rtl/ffa_wait_timer.sv
// rtl/ffa_wait_timer.sv - loadable down-counter shared by the inverse timeout and the drain delay
module ffa_wait_timer #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ffa_cmd_issuer.sv
// rtl/ffa_cmd_issuer.sv - sequences tagged commands into the GF(2^8) unit and returns one response each
module ffa_cmd_issuer
    import ffa_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic [7:0]       ffa_operA,
    output logic [7:0]       ffa_operB,
    output logic [2:0]       ffa_op_sel,
    input  logic             ffa_busy,
    input  logic [7:0]       ffa_result,
    output logic [7:0]       err_count
);

    localparam int MAX_CNT = (TIMEOUT_CYCLES > DRAIN_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    issuer_state_t    state, state_n;
    logic [7:0]       opa_n, opb_n, data_n, errc_n;
    logic [2:0]       sel_n;
    logic [1:0]       err_n;
    logic [TAG_W-1:0] tag_n;
    logic             inv_first, first_n;
    logic             tmr_load, tmr_en, tmr_expired;
    logic [CNT_W-1:0] tmr_value;

    ffa_wait_timer #(.W(CNT_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .enable     (tmr_en),
        .expired    (tmr_expired)
    );

    // ready must read low while reset is held even though state already reads IDLE
    assign cmd_ready = reset && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ffa_operA  <= '0;
            ffa_operB  <= '0;
            ffa_op_sel <= '0;
            rsp_data   <= '0;
            rsp_err    <= ERR_OK;
            rsp_tag    <= '0;
            err_count  <= '0;
            inv_first  <= 1'b0;
        end else begin
            state      <= state_n;
            ffa_operA  <= opa_n;
            ffa_operB  <= opb_n;
            ffa_op_sel <= sel_n;
            rsp_data   <= data_n;
            rsp_err    <= err_n;
            rsp_tag    <= tag_n;
            err_count  <= errc_n;
            inv_first  <= first_n;
        end
    end

    always_comb begin
        state_n   = state;
        opa_n     = ffa_operA;
        opb_n     = ffa_operB;
        sel_n     = ffa_op_sel;
        data_n    = rsp_data;
        err_n     = rsp_err;
        tag_n     = rsp_tag;
        errc_n    = err_count;
        first_n   = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tag_n = cmd_tag;
                    case (cmd_op)
                        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                            if (cmd_op == OP_DIV && cmd_b == 8'd0) begin
                                data_n  = 8'd0;
                                err_n   = ERR_DIV0;
                                state_n = ST_RESP;
                            end else begin
                                opa_n   = cmd_a;
                                opb_n   = cmd_b;
                                sel_n   = cmd_op;
                                state_n = ST_SETTLE;
                            end
                        end
                        OP_INV: begin
                            // 0 and 1 are their own inverses; skip the slow engine
                            if (cmd_a <= 8'd1) begin
                                data_n  = cmd_a;
                                err_n   = ERR_OK;
                                state_n = ST_RESP;
                            end else begin
                                opa_n     = cmd_a;
                                opb_n     = 8'd0;
                                sel_n     = OP_INV;
                                first_n   = 1'b1;
                                tmr_load  = 1'b1;
                                tmr_value = CNT_W'(TIMEOUT_CYCLES - 1);
                                state_n   = ST_INV_WAIT;
                            end
                        end
                        default: begin
                            data_n  = 8'd0;
                            err_n   = ERR_ILLEGAL;
                            state_n = ST_RESP;
                        end
                    endcase
                end
            end
            ST_SETTLE: begin
                data_n  = ffa_result;
                err_n   = ERR_OK;
                opa_n   = 8'd0;
                opb_n   = 8'd0;
                sel_n   = OP_ADD;
                state_n = ST_RESP;
            end
            ST_INV_WAIT: begin
                tmr_en = 1'b1;
                // busy may not have risen yet on the first cycle, so completion is ignored there
                if ((!inv_first && !ffa_busy) || tmr_expired) begin
                    data_n    = (!inv_first && !ffa_busy) ? ffa_result : 8'd0;
                    err_n     = (!inv_first && !ffa_busy) ? ERR_OK : ERR_TIMEOUT;
                    opa_n     = 8'd0;
                    sel_n     = OP_ADD;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(DRAIN_CYCLES - 1);
                    state_n   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                    if (rsp_err != ERR_OK && err_count != 8'hFF) begin
                        errc_n = err_count + 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ffa_cmd_issuer.sv
// tb/tb_ffa_cmd_issuer.sv - directed self-checking bench for ffa_cmd_issuer with a behavioural GF(2^8) unit
module tb_ffa_cmd_issuer;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 32;
    localparam int DRAIN   = 2;
    localparam int INV_LAT = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [7:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_err;
    logic [7:0]       ffa_operA, ffa_operB;
    logic [2:0]       ffa_op_sel;
    logic             ffa_busy;
    logic [7:0]       ffa_result;
    logic [7:0]       err_count;

    int checks = 0;
    int errors = 0;
    logic stuck = 1'b0;
    logic ready_leak;
    int sel4_cnt = 0;

    always #5 clock = ~clock;

    ffa_cmd_issuer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT), .DRAIN_CYCLES(DRAIN)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
        .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .ffa_operA(ffa_operA), .ffa_operB(ffa_operB), .ffa_op_sel(ffa_op_sel),
        .ffa_busy(ffa_busy), .ffa_result(ffa_result), .err_count(err_count)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'd0;
        for (int i = 1; i < 256; i++) begin
            if (gmul(a, 8'(i)) == 8'd1) r = 8'(i);
        end
        return r;
    endfunction

    // behavioural unit: inverse raises busy for INV_LAT cycles, done clears when op_sel leaves 4
    logic [7:0] inv_cnt = 8'd0;
    logic       inv_done = 1'b0;
    always @(posedge clock) begin
        if (ffa_op_sel != 3'd4) begin
            inv_cnt  <= 8'd0;
            inv_done <= 1'b0;
        end else if (!inv_done) begin
            inv_cnt <= inv_cnt + 8'd1;
            if (inv_cnt == 8'(INV_LAT - 1)) inv_done <= 1'b1;
        end
        if (ffa_op_sel == 3'd4) sel4_cnt <= sel4_cnt + 1;
    end
    assign ffa_busy = (ffa_op_sel == 3'd4) && (stuck || !inv_done);
    always_comb begin
        case (ffa_op_sel)
            3'd0, 3'd1: ffa_result = ffa_operA ^ ffa_operB;
            3'd2:       ffa_result = gmul(ffa_operA, ffa_operB);
            3'd3:       ffa_result = gmul(ffa_operA, ginv(ffa_operB));
            3'd4:       ffa_result = inv_done ? ginv(ffa_operA) : 8'd0;
            default:    ffa_result = 8'd0;
        endcase
    end

    // issues one command and waits for rsp_valid; lat is handshake-edge-to-valid in cycles
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, output int lat);
        int n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        ready_leak = 1'b0;
        while (!rsp_valid && n < 100) begin
            if (cmd_ready) ready_leak = 1'b1;
            @(posedge clock); #1;
            n++;
        end
        if (cmd_ready) ready_leak = 1'b1;
        lat = n + 1;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles for op %0d", n, op);
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #2;
        @(posedge clock); #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        checks++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_err, ffa_operA, ffa_operB, ffa_op_sel, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h tag=%h err=%b opA=%h opB=%h sel=%h cnt=%h expected all 0",
                     rsp_valid, rsp_data, rsp_tag, rsp_err, ffa_operA, ffa_operB, ffa_op_sel, err_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_mul();
        int lat;
        send(3'd2, 8'h57, 8'h83, 4'd3, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL mul_latency: got %0d expected 2", lat); end
        checks++;
        if ({rsp_data, rsp_tag, rsp_err} !== {8'hC1, 4'd3, 2'b00}) begin
            errors++; $display("FAIL mul_rsp: got data=%h tag=%h err=%b expected data=c1 tag=3 err=00", rsp_data, rsp_tag, rsp_err);
        end
        checks++;
        if (ffa_op_sel !== 3'd0) begin errors++; $display("FAIL mul_park: got op_sel=%0d expected 0", ffa_op_sel); end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(3'd0, 8'h57, 8'h83, 4'd1, lat);
        checks++;
        if ({rsp_data, rsp_tag, ready_leak} !== {8'hD4, 4'd1, 1'b0}) begin
            errors++; $display("FAIL add_rsp: got data=%h tag=%h ready_leak=%b expected d4 1 0", rsp_data, rsp_tag, ready_leak);
        end
        ack();
        send(3'd1, 8'hFF, 8'h0F, 4'd2, lat);
        checks++;
        if ({rsp_data, rsp_tag, rsp_err, ready_leak} !== {8'hF0, 4'd2, 2'b00, 1'b0}) begin
            errors++; $display("FAIL sub_rsp: got data=%h tag=%h err=%b ready_leak=%b expected f0 2 00 0",
                               rsp_data, rsp_tag, rsp_err, ready_leak);
        end
        ack();
        send(3'd3, 8'hC1, 8'h83, 4'd4, lat);
        checks++;
        if ({rsp_data, rsp_err} !== {8'h57, 2'b00} || lat !== 2) begin
            errors++; $display("FAIL div_rsp: got data=%h err=%b lat=%0d expected 57 00 2", rsp_data, rsp_err, lat);
        end
        ack();
    endtask

    task automatic test_inverse();
        int lat;
        int s4;
        send(3'd4, 8'h53, 8'h00, 4'd6, lat);
        checks++;
        if ({rsp_data, rsp_tag, rsp_err} !== {8'hCA, 4'd6, 2'b00}) begin
            errors++; $display("FAIL inv_rsp: got data=%h tag=%h err=%b expected ca 6 00", rsp_data, rsp_tag, rsp_err);
        end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL inv_latency: got %0d expected 9", lat); end
        ack();
        s4 = sel4_cnt;
        send(3'd4, 8'h01, 8'h00, 4'd7, lat);
        checks++;
        if ({rsp_data, rsp_err, lat[3:0]} !== {8'h01, 2'b00, 4'd1} || sel4_cnt != s4) begin
            errors++; $display("FAIL inv_one: got data=%h err=%b lat=%0d sel4_cycles=%0d expected 01 00 1 0",
                               rsp_data, rsp_err, lat, sel4_cnt - s4);
        end
        ack();
    endtask

    task automatic test_errors();
        int lat;
        send(3'd3, 8'h44, 8'h00, 4'd8, lat);
        checks++;
        if ({rsp_data, rsp_err, lat[3:0]} !== {8'h00, 2'b01, 4'd1}) begin
            errors++; $display("FAIL div0_rsp: got data=%h err=%b lat=%0d expected 00 01 1", rsp_data, rsp_err, lat);
        end
        ack();
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL div0_count: got %0d expected 1", err_count); end
        send(3'd6, 8'h12, 8'h34, 4'd9, lat);
        checks++;
        if ({rsp_data, rsp_err, rsp_tag} !== {8'h00, 2'b11, 4'd9}) begin
            errors++; $display("FAIL illegal_rsp: got data=%h err=%b tag=%h expected 00 11 9", rsp_data, rsp_err, rsp_tag);
        end
        ack();
        checks++;
        if (err_count !== 8'd2) begin errors++; $display("FAIL illegal_count: got %0d expected 2", err_count); end
        stuck = 1'b1;
        send(3'd4, 8'h10, 8'h00, 4'd10, lat);
        checks++;
        if ({rsp_data, rsp_err} !== {8'h00, 2'b10} || lat !== 35) begin
            errors++; $display("FAIL timeout_rsp: got data=%h err=%b lat=%0d expected 00 10 35", rsp_data, rsp_err, lat);
        end
        ack();
        stuck = 1'b0;
        checks++;
        if (err_count !== 8'd3) begin errors++; $display("FAIL timeout_count: got %0d expected 3", err_count); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic moved = 1'b0;
        rsp_ready = 1'b0;
        send(3'd2, 8'h02, 8'h03, 4'd5, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if ({rsp_valid, rsp_data, rsp_tag, rsp_err} !== {1'b1, 8'h06, 4'd5, 2'b00}) moved = 1'b1;
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++; $display("FAIL backpressure_stable: got valid=%b data=%h tag=%h err=%b expected 1 06 5 00 throughout",
                               rsp_valid, rsp_data, rsp_tag, rsp_err);
        end
        ack();
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL backpressure_release: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic saw_rsp = 1'b0;
        stuck = 1'b1;
        cmd_op = 3'd4; cmd_a = 8'h10; cmd_b = 8'h00; cmd_tag = 4'd11; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, ffa_operA, ffa_operB, ffa_op_sel, err_count} !== '0) begin
            errors++; $display("FAIL reset_mid_op: got ready=%b valid=%b data=%h tag=%h err=%b opA=%h opB=%h sel=%h cnt=%h expected all 0",
                               cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, ffa_operA, ffa_operB, ffa_op_sel, err_count);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        stuck = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp !== 1'b0) begin errors++; $display("FAIL reset_no_rsp: got rsp_valid after reset expected none"); end
        send(3'd0, 8'h0F, 8'hF0, 4'd12, lat);
        checks++;
        if ({rsp_data, rsp_tag, rsp_err} !== {8'hFF, 4'd12, 2'b00}) begin
            errors++; $display("FAIL post_reset_add: got data=%h tag=%h err=%b expected ff c 00", rsp_data, rsp_tag, rsp_err);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_inverse();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
